bnn_load_tx: RTL and testbench
==============================

# bnn_load_tx

Serial transmitter for the BNN load stream. On `start`, it reads the pixel image and all layer weights from two byte-wide synchronous memories. It serializes them LSB-first into the two 1-bit streams (`d_out_p`, `d_out_w`) that the on-chip loader consumes one bit per cycle while in LOAD. It also drives `load_en`, which the top controller uses to hold the design in LOAD for exactly the stream duration.

## Interface
Parameters:
- `PIX_BITS`, 784: pixel stream length (28×28).
- `W_BITS`, 2320: weight stream length (72 L1 + 288 L2 + 1960 L3).

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begin a transfer. Sampled only in IDLE.
- `p_re`  out  1: pixel memory read enable.
- `p_addr`  out  7: pixel byte address, 0..97.
- `p_rdata`  in  8: pixel byte. Valid the cycle after `p_re`/`p_addr`.
- `w_re`  out  1: weight memory read enable.
- `w_addr`  out  9: weight byte address, 0..289.
- `w_rdata`  in  8: weight byte. Valid the cycle after `w_re`/`w_addr`.
- `d_out_p`  out  1: pixel serial bit.
- `d_out_w`  out  1: weight serial bit.
- `load_en`  out  1: high on every stream cycle, and only then.
- `busy`  out  1: high from PRE1 through STREAM.
- `done`  out  1: one-cycle pulse after the final stream cycle.

## Operation
- FSM states: IDLE, PRE1, PRE2, STREAM, DONE.
  - IDLE: `start=1` → PRE1.
  - PRE1 → PRE2.
  - PRE2 → STREAM.
  - STREAM: stays for W_BITS cycles, then → DONE.
  - DONE → IDLE.
- `start` outside IDLE is ignored. No queuing.
- Stream bit n (0..W_BITS-1) is emitted on stream cycle n.
  - `d_out_w` = `w_byte[n>>3][n&7]`.
  - `d_out_p` = `p_byte[n>>3][n&7]` for n < PIX_BITS, else 0.
- Mapping to the loader:
  - Pixel bit n lands in `pixels[n]`, with n = row*28+col.
  - Weight bits 0..71 go to L1, 72..359 to L2, 360..2319 to L3.
  - This block does not reorder bits. Memory contents must already be in stream order.
- Buffering, per stream: shift register `sr` plus next-byte register `nb`.
  - PRE1: drive addr 0 with `re=1`.
  - PRE2: capture rdata into `sr`. Drive addr 1 with `re=1`.
  - First STREAM cycle: capture rdata into `nb`.
  - Output bit is `sr[0]`, right-shift each stream cycle.
  - On the cycle emitting bit 7 of byte k, `sr <= nb` at the clock edge.
  - On the cycle emitting bit 0 of byte k+1 (k ≥ 0), drive addr k+2 if it is ≤ last byte (97 pixel / 289 weight). Capture into `nb` the next cycle.
  - Byte 1 is the exception: it is prefetched in PRE2. Consequently, addr k+2 is issued for k+1 ≥ 1.
- `re` is high only on address-issue cycles. No reads past the last byte. The pixel port goes idle after byte 97, while weights continue.
- Counters and widths:
  - Bit counter: 12 bits, 0..2319. Compared against W_BITS-1 for the exit condition.
  - Byte addresses saturate at the last byte. They never wrap to 0 during a transfer.
- Reset in any state (synchronous):
  - State → IDLE.
  - All outputs and internal registers → 0, including `addr`, `re`, `d_out_*`, `load_en`, `busy`, `done`.
  - A partial transfer is abandoned. A new `start` restarts from byte 0.

## Timing
- `start` is sampled at edge E0. PRE1 = cycle 1, PRE2 = cycle 2.
- `load_en` is high in cycles 3 .. 3+W_BITS-1 (2322), for exactly 2320 cycles.
- `d_out_p` is valid in cycles 3..786. It is 0 in cycles 787..2322.
- `done=1` in cycle 2323. `busy` is high in cycles 1..2322.
- IDLE is reached at cycle 2324. A `start` in cycle 2324 is accepted, giving a back-to-back period of 2324 cycles.
- All outputs are registered or driven directly from flops. No combinational path from rdata to `d_out`.
- Memory read latency is fixed at 1 cycle. Other latencies are unsupported.

## Test plan
- Pixel memory all 0xA5, weight memory all 0x3C, `start` pulsed → the following streams, and `done` in cycle 2323:
  - `d_out_p`: 1,0,1,0,0,1,0,1 repeating for 784 cycles, then 0.
  - `d_out_w`: 0,0,1,1,1,1,0,0 repeating for 2320 cycles.
- Incrementing memories (byte k = k mod 256) → decoded bytes match address order. `p_addr` never exceeds 97 and `w_addr` never exceeds 289. Count of `p_re` pulses = 98, count of `w_re` pulses = 290.
- `start` held high continuously → exactly one transfer every 2324 cycles. `start` during STREAM has no effect.
- Connect to the loader, with `state` = LOAD while `load_en` is high → loader `load_done=1` after cycle 2322. `pixels`, `weights1`, `weights2`, `weights3` equal the memory images bit for bit.
- `reset_n=0` for 1 cycle at stream cycle 1000, then `start` → all outputs read 0 on the cycle after reset. The new transfer begins at byte 0 and completes correctly.
- Last-byte boundary: weight byte 289 = 0x80 → `d_out_w` is 0 for stream cycles 2312..2318 and 1 on cycle 2319. `load_en` falls after cycle 2322 absolute.

Source files
------------

// File: rtl/bnn_load_tx.sv
// Serial transmitter for the BNN load stream: fetches pixel and weight bytes from
// two 1-cycle-latency memories and shifts them out LSB-first, one bit per cycle.
module bnn_load_tx #(
    parameter int PIX_BITS = 784,
    parameter int W_BITS   = 2320
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       p_re,
    output logic [6:0] p_addr,
    input  logic [7:0] p_rdata,
    output logic       w_re,
    output logic [8:0] w_addr,
    input  logic [7:0] w_rdata,
    output logic       d_out_p,
    output logic       d_out_w,
    output logic       load_en,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0]  P_LAST = 10'((PIX_BITS + 7) / 8 - 1);
    localparam logic [9:0]  W_LAST = 10'((W_BITS + 7) / 8 - 1);
    localparam logic [11:0] CNT_END = 12'(W_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE1,
        PRE2,
        STREAM,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] cnt;
    logic [11:0] cnt_nx;
    logic [9:0]  nx_byte;
    logic [9:0]  cur_next;
    logic        issue_next;
    logic [7:0]  sr_p;
    logic [7:0]  nb_p;
    logic [7:0]  sr_w;
    logic [7:0]  nb_w;
    logic        pend_p;
    logic        pend_w;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PRE1;
            PRE1:    state_next = PRE2;
            PRE2:    state_next = STREAM;
            STREAM:  if (cnt == CNT_END) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A read for byte m+1 is issued on the cycle that emits bit 0 of byte m (m >= 1),
    // so the data lands in nb well before the byte boundary at bit 7.
    always_comb begin
        cnt_nx     = cnt + 12'd1;
        nx_byte    = {1'b0, cnt_nx[11:3]} + 10'd1;
        cur_next   = {1'b0, cnt[11:3]} + 10'd1;
        issue_next = (state == STREAM) && (cnt_nx[2:0] == 3'd0) && (cnt_nx[11:3] != 9'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            p_re    <= 1'b0;
            p_addr  <= '0;
            w_re    <= 1'b0;
            w_addr  <= '0;
            sr_p    <= '0;
            nb_p    <= '0;
            sr_w    <= '0;
            nb_w    <= '0;
            pend_p  <= 1'b0;
            pend_w  <= 1'b0;
            load_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            load_en <= (state_next == STREAM);
            busy    <= (state_next == PRE1) || (state_next == PRE2) || (state_next == STREAM);
            done    <= (state_next == DONE);
            cnt     <= ((state == STREAM) && (state_next == STREAM)) ? cnt_nx : 12'd0;
            pend_p  <= p_re;
            pend_w  <= w_re;

            p_re <= 1'b0;
            w_re <= 1'b0;
            if ((state == IDLE) && start) begin
                p_re   <= 1'b1;
                p_addr <= 7'd0;
                w_re   <= 1'b1;
                w_addr <= 9'd0;
            end else if (state == PRE1) begin
                p_re   <= 1'b1;
                p_addr <= 7'd1;
                w_re   <= 1'b1;
                w_addr <= 9'd1;
            end else if (issue_next) begin
                if (nx_byte <= P_LAST) begin
                    p_re   <= 1'b1;
                    p_addr <= nx_byte[6:0];
                end
                if (nx_byte <= W_LAST) begin
                    w_re   <= 1'b1;
                    w_addr <= nx_byte[8:0];
                end
            end

            // Past the last byte the shift register refills with zeros, which also
            // leaves both serial outputs low once the stream is over.
            if (state == STREAM) begin
                if (cnt[2:0] == 3'd7) begin
                    sr_p <= (cur_next <= P_LAST) ? nb_p : 8'h00;
                    sr_w <= (cur_next <= W_LAST) ? nb_w : 8'h00;
                end else begin
                    sr_p <= sr_p >> 1;
                    sr_w <= sr_w >> 1;
                end
            end

            if (pend_p) begin
                if (state == PRE2) sr_p <= p_rdata;
                else               nb_p <= p_rdata;
            end
            if (pend_w) begin
                if (state == PRE2) sr_w <= w_rdata;
                else               nb_w <= w_rdata;
            end
        end
    end

    assign d_out_p = sr_p[0];
    assign d_out_w = sr_w[0];

endmodule

// File: tb/tb_bnn_load_tx.sv
// Scoreboard bench for bnn_load_tx: expected bit pairs are queued from the memory
// images at start and popped on every load_en cycle.
module tb_bnn_load_tx;

    localparam int PIX_BITS = 784;
    localparam int W_BITS   = 2320;
    localparam int P_BYTES  = 98;
    localparam int W_BYTES  = 290;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       p_re;
    logic [6:0] p_addr;
    logic [7:0] p_rdata;
    logic       w_re;
    logic [8:0] w_addr;
    logic [7:0] w_rdata;
    logic       d_out_p;
    logic       d_out_w;
    logic       load_en;
    logic       busy;
    logic       done;

    logic [7:0] pmem [P_BYTES];
    logic [7:0] wmem [W_BYTES];
    logic [1:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    bnn_load_tx #(.PIX_BITS(PIX_BITS), .W_BITS(W_BITS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .p_re(p_re), .p_addr(p_addr), .p_rdata(p_rdata),
        .w_re(w_re), .w_addr(w_addr), .w_rdata(w_rdata),
        .d_out_p(d_out_p), .d_out_w(d_out_w),
        .load_en(load_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        if (p_re) p_rdata <= (int'(p_addr) < P_BYTES) ? pmem[p_addr] : 8'hxx;
        if (w_re) w_rdata <= (int'(w_addr) < W_BYTES) ? wmem[w_addr] : 8'hxx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [20:0] all_outputs();
        return {p_re, p_addr, w_re, w_addr, d_out_p, d_out_w, load_en, busy, done};
    endfunction

    task automatic push_expected();
        logic [7:0] pb;
        logic [7:0] wb;
        exp_q.delete();
        for (int n = 0; n < W_BITS; n++) begin
            pb = (n < PIX_BITS) ? pmem[n / 8] : 8'h00;
            wb = wmem[n / 8];
            exp_q.push_back({pb[n % 8], wb[n % 8]});
        end
    endtask

    // Called at a negedge that is cycle 0 of the transfer; returns at the negedge of
    // cycle 2324 (back in IDLE) or of the cycle after an injected reset.
    task automatic run_transfer(input string name, input bit hold, input int abort_at, input bit chk_last);
        int         first_le = -1;
        int         last_le  = -1;
        int         done_cyc = -1;
        int         n_done   = 0;
        int         n_pre    = 0;
        int         n_wre    = 0;
        int         max_pa   = 0;
        int         max_wa   = 0;
        logic [1:0] e;
        push_expected();
        start = 1'b1;
        for (int t = 1; t <= 2400; t++) begin
            @(negedge clk);
            if (!hold && (t == 1 || t == 1004)) start = 1'b0;
            if (!hold && t == 1003) start = 1'b1;
            if (p_re) n_pre++;
            if (w_re) n_wre++;
            if (int'(p_addr) > max_pa) max_pa = int'(p_addr);
            if (int'(w_addr) > max_wa) max_wa = int'(w_addr);
            if (load_en) begin
                if (first_le < 0) first_le = t;
                last_le = t;
                if (exp_q.size() == 0) begin
                    check({name, " queue underflow"}, 32'(t), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check({name, " stream bits"}, 32'({d_out_p, d_out_w}), 32'(e));
                end
                if (chk_last && t - 3 == W_BITS - 1) check({name, " last w bit"}, 32'(d_out_w), 32'(1));
                if (chk_last && t - 3 == W_BITS - 8) check({name, " w bit 2312"}, 32'(d_out_w), 32'(0));
            end
            if (done) begin
                n_done++;
                done_cyc = t;
            end
            if (abort_at > 0 && t == 3 + abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check({name, " outputs after reset"}, 32'(all_outputs()), 32'(0));
                reset_n = 1'b1;
                exp_q.delete();
                return;
            end
            if (done) break;
        end
        check({name, " done cycle"}, 32'(done_cyc), 32'(2323));
        check({name, " done pulses"}, 32'(n_done), 32'(1));
        check({name, " load_en first"}, 32'(first_le), 32'(3));
        check({name, " load_en last"}, 32'(last_le), 32'(2322));
        check({name, " leftover"}, 32'(exp_q.size()), 32'(0));
        check({name, " p_re count"}, 32'(n_pre), 32'(P_BYTES));
        check({name, " w_re count"}, 32'(n_wre), 32'(W_BYTES));
        check({name, " p_addr max"}, 32'(max_pa), 32'(P_BYTES - 1));
        check({name, " w_addr max"}, 32'(max_wa), 32'(W_BYTES - 1));
        @(negedge clk);
        check({name, " idle flags"}, 32'({load_en, busy, done}), 32'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(all_outputs()), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle without start", 32'({busy, load_en, p_re}), 32'(0));

        for (int i = 0; i < P_BYTES; i++) pmem[i] = 8'hA5;
        for (int i = 0; i < W_BYTES; i++) wmem[i] = 8'h3C;
        run_transfer("pattern", 1'b0, 0, 1'b0);

        for (int i = 0; i < P_BYTES; i++) pmem[i] = 8'(i);
        for (int i = 0; i < W_BYTES; i++) wmem[i] = 8'(i);
        run_transfer("increment", 1'b0, 0, 1'b0);

        for (int i = 0; i < P_BYTES; i++) pmem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < W_BYTES; i++) wmem[i] = 8'($urandom_range(0, 255));
        wmem[W_BYTES - 1] = 8'h80;
        run_transfer("abort", 1'b0, 1000, 1'b0);
        run_transfer("restart", 1'b0, 0, 1'b1);

        run_transfer("held start 1", 1'b1, 0, 1'b1);
        run_transfer("held start 2", 1'b0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
